debo_ndig_scan: RTL and testbench

- Parametrised multiplexed 7-segment display driver; successor to the single-digit hex decoder.
- Holds NDIG hex nibbles with per-digit decimal point and blank bits, and time-multiplexes them onto one shared segment bus with one-hot digit strobes.
- Includes a load handshake that updates only at frame boundaries (no tearing) and an anti-ghosting guard interval.
- Sits between counter/ALU datapaths and board display pins.

---
 rtl/debo_ndig_scan.sv | 169 ++++++++++++++++
 tb/tb_debo_ndig_scan.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debo_ndig_scan.sv
// Multiplexed NDIG-digit 7-segment scanner with frame-aligned load handshake and anti-ghosting guard.
// Optional macro LZB_EN enables leading-zero blanking.
module debo_ndig_scan #(
    parameter int unsigned NDIG  = 4,
    parameter int unsigned PRESC = 50000,
    parameter int unsigned GUARD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] A,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   blank,
    input  logic              ld,
    output logic [6:0]        L,
    output logic              H,
    output logic [NDIG-1:0]   dig,
    output logic              frm,
    output logic              pend
);

    localparam int unsigned CW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned SW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_slot;
    logic [4*NDIG-1:0] r_act_a,  r_pnd_a;
    logic [NDIG-1:0]   r_act_dp, r_pnd_dp;
    logic [NDIG-1:0]   r_act_bl, r_pnd_bl;
    logic              r_pend;
    logic              r_frm;
    logic [6:0]        r_l;
    logic              r_h;
    logic [NDIG-1:0]   r_dig;

    logic              w_tick;
    logic              w_wrap;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg;
    logic [NDIG-1:0]   w_dark;
    logic [6:0]        w_l_n;
    logic              w_h_n;
    logic [NDIG-1:0]   w_dig_n;

    assign w_tick = (r_cnt == CW'(PRESC - 1));
    assign w_wrap = w_tick && (r_slot == SW'(NDIG - 1));
    assign w_nib  = r_act_a[{r_slot, 2'b00} +: 4];

    // Prescaler and slot sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_slot <= '0;
            r_frm  <= 1'b0;
        end else begin
            r_frm <= w_wrap;
            if (w_tick) begin
                r_cnt  <= '0;
                r_slot <= w_wrap ? '0 : r_slot + SW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Load handshake: active set only changes on the frame wrap, so a frame never mixes values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_a  <= '0;
            r_act_dp <= '0;
            r_act_bl <= '1;
            r_pnd_a  <= '0;
            r_pnd_dp <= '0;
            r_pnd_bl <= '1;
            r_pend   <= 1'b0;
        end else if (w_wrap) begin
            if (ld) begin
                r_act_a  <= A;
                r_act_dp <= dp;
                r_act_bl <= blank;
            end else if (r_pend) begin
                r_act_a  <= r_pnd_a;
                r_act_dp <= r_pnd_dp;
                r_act_bl <= r_pnd_bl;
            end
            r_pend <= 1'b0;
        end else if (ld) begin
            r_pnd_a  <= A;
            r_pnd_dp <= dp;
            r_pnd_bl <= blank;
            r_pend   <= 1'b1;
        end
    end

    // Hex to active-low gfedcba
    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

`ifdef LZB_EN
    logic w_lead;

    // Leading zeros (no dp) go dark from the top digit down; digit 0 always shows
    always_comb begin
        w_dark = r_act_bl;
        w_lead = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (w_lead && (r_act_a[4*i +: 4] == 4'h0) && !r_act_dp[i]) begin
                w_dark[i] = 1'b1;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_dark = r_act_bl;
    end
`endif

    // Next output values; strobes stay off during the guard cycles of each slot
    always_comb begin
        w_dig_n = '1;
        w_l_n   = 7'h7F;
        w_h_n   = 1'b1;
        if ((r_cnt >= CW'(GUARD)) && !w_dark[r_slot]) begin
            w_dig_n = ~(NDIG'(1) << r_slot);
            w_l_n   = w_seg;
            w_h_n   = ~r_act_dp[r_slot];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig <= '1;
            r_l   <= 7'h7F;
            r_h   <= 1'b1;
        end else begin
            r_dig <= w_dig_n;
            r_l   <= w_l_n;
            r_h   <= w_h_n;
        end
    end

    assign L    = r_l;
    assign H    = r_h;
    assign dig  = r_dig;
    assign frm  = r_frm;
    assign pend = r_pend;

endmodule

// File: tb/tb_debo_ndig_scan.sv
// Directed bench for debo_ndig_scan with NDIG=4, PRESC=4, GUARD=1 (16-cycle frame).
module tb_debo_ndig_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        ld;
    logic [6:0]  L;
    logic        H;
    logic [3:0]  dig;
    logic        frm;
    logic        pend;

    int n_cmp;
    int n_err;

    logic [3:0] cap_dig  [1:16];
    logic [6:0] cap_L    [1:16];
    logic       cap_H    [1:16];
    logic       cap_pend [1:16];
    logic       cap_frm  [1:16];

    logic [6:0] eL [4];
    logic [3:0] edark;
    logic [3:0] edp;
    int         s, c;
    logic       lit;
    logic [3:0] xd;
    logic [6:0] xl;
    logic       xh;

    debo_ndig_scan #(.NDIG(4), .PRESC(4), .GUARD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .dp    (dp),
        .blank (blank),
        .ld    (ld),
        .L     (L),
        .H     (H),
        .dig   (dig),
        .frm   (frm),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance until a frm pulse is seen at a negedge; optionally require pend=1 while waiting
    task automatic wait_frm(input bit chk_pend);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (frm === 1'b1) begin
                seen = 1'b1;
            end else if (chk_pend) begin
                n_cmp++;
                if (pend !== 1'b1) begin
                    n_err++;
                    $display("FAIL wait_pend k=%0d pend=%b want 1", k, pend);
                end
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_frm timeout frm=%b want 1", frm);
        end
    endtask

    // Record 16 negedge samples following the current frm cycle
    task automatic capture_frame();
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            cap_dig[j]  = dig;
            cap_L[j]    = L;
            cap_H[j]    = H;
            cap_pend[j] = pend;
            cap_frm[j]  = frm;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; A = '0; dp = '0; blank = '0; ld = 1'b0;
        #12;
        n_cmp++; if (dig !== 4'hF)  begin n_err++; $display("FAIL reset_dig got %h want f", dig); end
        n_cmp++; if (L !== 7'h7F)   begin n_err++; $display("FAIL reset_L got %h want 7f", L); end
        n_cmp++; if (H !== 1'b1)    begin n_err++; $display("FAIL reset_H got %b want 1", H); end
        n_cmp++; if (frm !== 1'b0)  begin n_err++; $display("FAIL reset_frm got %b want 0", frm); end
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL reset_pend got %b want 0", pend); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dig !== 4'hF || L !== 7'h7F || H !== 1'b1 || frm !== (k % 16 == 0)) begin
                n_err++;
                $display("FAIL idle k=%0d dig=%h L=%h H=%b frm=%b want f/7f/1/%0d", k, dig, L, H, frm, (k % 16 == 0));
            end
        end
    endtask

    task automatic test_load();
        A = 16'h12AF; dp = 4'b0000; blank = 4'b0000; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL load_pend got %b want 1", pend); end
        wait_frm(1'b1);
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL load_pend_clr got %b want 0", pend); end
        capture_frame();
        eL[0] = 7'h0E; eL[1] = 7'h08; eL[2] = 7'h24; eL[3] = 7'h79; edark = 4'b0000; edp = 4'b0000;
        for (int j = 1; j <= 16; j++) begin
            s = (j - 1) / 4; c = (j - 1) % 4;
            lit = (c >= 1) && !edark[s];
            xd = lit ? ~(4'b0001 << s) : 4'hF;
            xl = lit ? eL[s] : 7'h7F;
            xh = lit ? ~edp[s] : 1'b1;
            n_cmp++;
            if (cap_dig[j] !== xd || cap_L[j] !== xl || cap_H[j] !== xh) begin
                n_err++;
                $display("FAIL load j=%0d dig=%h/%h L=%h/%h H=%b/%b", j, cap_dig[j], xd, cap_L[j], xl, cap_H[j], xh);
            end
        end
        n_cmp++; if (cap_frm[16] !== 1'b1) begin n_err++; $display("FAIL load_frm got %b want 1", cap_frm[16]); end
    endtask

    task automatic test_dp();
        A = 16'h12AF; dp = 4'b0100; blank = 4'b0000; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_frm(1'b1);
        capture_frame();
        eL[0] = 7'h0E; eL[1] = 7'h08; eL[2] = 7'h24; eL[3] = 7'h79; edark = 4'b0000; edp = 4'b0100;
        for (int j = 1; j <= 16; j++) begin
            s = (j - 1) / 4; c = (j - 1) % 4;
            lit = (c >= 1) && !edark[s];
            xd = lit ? ~(4'b0001 << s) : 4'hF;
            xl = lit ? eL[s] : 7'h7F;
            xh = lit ? ~edp[s] : 1'b1;
            n_cmp++;
            if (cap_dig[j] !== xd || cap_L[j] !== xl || cap_H[j] !== xh) begin
                n_err++;
                $display("FAIL dp j=%0d dig=%h/%h L=%h/%h H=%b/%b", j, cap_dig[j], xd, cap_L[j], xl, cap_H[j], xh);
            end
        end
    endtask

    task automatic test_last_wins();
        A = 16'h1111; dp = 4'b0000; blank = 4'b0000; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        A = 16'h2222; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_frm(1'b1);
        capture_frame();
        eL[0] = 7'h24; eL[1] = 7'h24; eL[2] = 7'h24; eL[3] = 7'h24; edark = 4'b0000; edp = 4'b0000;
        for (int j = 1; j <= 16; j++) begin
            s = (j - 1) / 4; c = (j - 1) % 4;
            lit = (c >= 1) && !edark[s];
            xd = lit ? ~(4'b0001 << s) : 4'hF;
            xl = lit ? eL[s] : 7'h7F;
            n_cmp++;
            if (cap_dig[j] !== xd || cap_L[j] !== xl || cap_L[j] === 7'h79) begin
                n_err++;
                $display("FAIL last_wins j=%0d dig=%h/%h L=%h/%h", j, cap_dig[j], xd, cap_L[j], xl);
            end
        end
    endtask

    task automatic test_wrap_ld();
        repeat (15) @(negedge clk);
        A = 16'h3456; dp = 4'b0000; blank = 4'b0101; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        n_cmp++; if (frm !== 1'b1)  begin n_err++; $display("FAIL wrap_frm got %b want 1", frm); end
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL wrap_pend got %b want 0", pend); end
        capture_frame();
        eL[0] = 7'h02; eL[1] = 7'h12; eL[2] = 7'h19; eL[3] = 7'h30; edark = 4'b0101; edp = 4'b0000;
        for (int j = 1; j <= 16; j++) begin
            s = (j - 1) / 4; c = (j - 1) % 4;
            lit = (c >= 1) && !edark[s];
            xd = lit ? ~(4'b0001 << s) : 4'hF;
            xl = lit ? eL[s] : 7'h7F;
            n_cmp++;
            if (cap_dig[j] !== xd || cap_L[j] !== xl || cap_pend[j] !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_ld j=%0d dig=%h/%h L=%h/%h pend=%b/0", j, cap_dig[j], xd, cap_L[j], xl, cap_pend[j]);
            end
        end
    endtask

    task automatic test_zero(input logic [3:0] blk);
        A = 16'h0050; dp = 4'b0000; blank = blk; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_frm(1'b1);
        capture_frame();
        eL[0] = 7'h40; eL[1] = 7'h12; eL[2] = 7'h40; eL[3] = 7'h40; edp = 4'b0000;
`ifdef LZB_EN
        edark = blk | 4'b1100;
`else
        edark = blk;
`endif
        for (int j = 1; j <= 16; j++) begin
            s = (j - 1) / 4; c = (j - 1) % 4;
            lit = (c >= 1) && !edark[s];
            xd = lit ? ~(4'b0001 << s) : 4'hF;
            xl = lit ? eL[s] : 7'h7F;
            n_cmp++;
            if (cap_dig[j] !== xd || cap_L[j] !== xl) begin
                n_err++;
                $display("FAIL zero blk=%b j=%0d dig=%h/%h L=%h/%h", blk, j, cap_dig[j], xd, cap_L[j], xl);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (6) @(negedge clk);
        A = 16'hFFFF; dp = 4'b1111; blank = 4'b0000; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dig !== 4'hF || L !== 7'h7F || H !== 1'b1 || pend !== 1'b0 || frm !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset dig=%h L=%h H=%b pend=%b frm=%b want f/7f/1/0/0", dig, L, H, pend, frm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dig !== 4'hF || L !== 7'h7F || pend !== 1'b0 || frm !== (k == 16)) begin
                n_err++;
                $display("FAIL post_reset k=%0d dig=%h L=%h pend=%b frm=%b", k, dig, L, pend, frm);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_idle();
        test_load();
        test_dp();
        test_last_wins();
        test_wrap_ld();
        test_zero(4'b0000);
        test_zero(4'b0001);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
